// File: rtl/linealizador_pwl_if.sv
// rtl/linealizador_pwl_if.sv - start/ack, sample and coefficient-load bundle for linealizador_pwl
interface linealizador_pwl_if #(
    parameter int W        = 32,
    parameter int FRAC     = 16,
    parameter int SEG_BITS = 4,
    parameter int CH       = 4
);
    localparam int CHB = (CH > 1) ? $clog2(CH) : 1;

    logic                    Begin_FSM_LN;
    logic [W-1:0]            T;
    logic [CHB-1:0]          CH_SEL;
    logic                    COEF_WE;
    logic [CHB+SEG_BITS:0]   COEF_ADDR;
    logic [W-1:0]            COEF_DATA;
    logic                    ACK_LN;
    logic                    O_F;
    logic                    U_F;
    logic [W-1:0]            RESULT;

    modport master (
        output Begin_FSM_LN, T, CH_SEL, COEF_WE, COEF_ADDR, COEF_DATA,
        input  ACK_LN, O_F, U_F, RESULT
    );

    modport slave (
        input  Begin_FSM_LN, T, CH_SEL, COEF_WE, COEF_ADDR, COEF_DATA,
        output ACK_LN, O_F, U_F, RESULT
    );
endinterface

// File: rtl/linealizador_pwl.sv
// rtl/linealizador_pwl.sv - multi-channel piecewise-linear linearizer, RESULT = m*T + b with saturation
// Define LN_ROUND_EN for round-half-up before the fractional shift; default build truncates toward -inf.
module linealizador_pwl #(
    parameter int W        = 32,
    parameter int FRAC     = 16,
    parameter int SEG_BITS = 4,
    parameter int CH       = 4
) (
    input  logic               CLK,
    input  logic               RST_LN,
    linealizador_pwl_if.slave  bus
);
    localparam int CHB  = (CH > 1) ? $clog2(CH) : 1;
    localparam int SEGS = 1 << SEG_BITS;

    localparam logic signed [W:0]   ONE_Q = (W+1)'(1) << FRAC;
    localparam logic signed [2*W:0] S_MAX = $signed(((2*W+1)'(1) << (W-1)) - (2*W+1)'(1));
    localparam logic signed [2*W:0] S_MIN = -$signed((2*W+1)'(1) << (W-1));
    localparam logic [W-1:0]        RES_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]        RES_MIN = {1'b1, {(W-1){1'b0}}};
`ifdef LN_ROUND_EN
    localparam logic signed [2*W:0] HALF = (2*W+1)'(1) << (FRAC-1);
`endif

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MULT, S_ADD, S_DONE} state_t;

    state_t                  r_state;
    logic signed [W-1:0]     r_slope [CH][SEGS];
    logic signed [W-1:0]     r_icpt  [CH][SEGS];
    logic signed [W-1:0]     r_t;
    logic signed [W-1:0]     r_m;
    logic signed [W-1:0]     r_b;
    logic [CHB-1:0]          r_ch;
    logic signed [2*W-1:0]   r_prod;
    logic                    r_ack;
    logic                    r_of;
    logic                    r_uf;
    logic [W-1:0]            r_result;

    logic [CHB-1:0]          w_wr_ch;
    logic [SEG_BITS-1:0]     w_wr_seg;
    logic                    w_wr_sel;
    logic [SEG_BITS-1:0]     w_seg;
    logic signed [2*W-1:0]   w_prod;
    logic signed [2*W:0]     w_p_ext;
    logic signed [2*W:0]     w_q;
    logic signed [2*W:0]     w_sum;

    function automatic logic ch_ok(input logic [CHB-1:0] c);
        int v;
        v = int'(c);
        return v < CH;
    endfunction

    assign w_wr_ch  = bus.COEF_ADDR[CHB+SEG_BITS -: CHB];
    assign w_wr_seg = bus.COEF_ADDR[SEG_BITS:1];
    assign w_wr_sel = bus.COEF_ADDR[0];

    // Coefficient RAM has no reset so its contents survive RST_LN.
    always_ff @(posedge CLK) begin
        if (r_state == S_IDLE && bus.COEF_WE && ch_ok(w_wr_ch)) begin
            if (w_wr_sel) r_icpt[w_wr_ch][w_wr_seg]  <= bus.COEF_DATA;
            else          r_slope[w_wr_ch][w_wr_seg] <= bus.COEF_DATA;
        end
    end

    // Out-of-domain samples extrapolate along the first or last segment.
    always_comb begin
        w_seg = r_t[FRAC-1 -: SEG_BITS];
        if (r_t[W-1])
            w_seg = '0;
        else if ($signed({r_t[W-1], r_t}) >= ONE_Q)
            w_seg = '1;
    end

    always_comb begin
        w_prod  = $signed({{W{r_m[W-1]}}, r_m}) * $signed({{W{r_t[W-1]}}, r_t});
`ifdef LN_ROUND_EN
        w_p_ext = $signed({r_prod[2*W-1], r_prod}) + HALF;
`else
        w_p_ext = $signed({r_prod[2*W-1], r_prod});
`endif
        w_q     = w_p_ext >>> FRAC;
        w_sum   = w_q + $signed({{(W+1){r_b[W-1]}}, r_b});
    end

    always_ff @(posedge CLK) begin
        if (RST_LN) begin
            r_state  <= S_IDLE;
            r_ack    <= 1'b0;
            r_of     <= 1'b0;
            r_uf     <= 1'b0;
            r_result <= '0;
            r_t      <= '0;
            r_ch     <= '0;
            r_m      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Begin_FSM_LN) begin
                        r_t     <= bus.T;
                        r_ch    <= ch_ok(bus.CH_SEL) ? bus.CH_SEL : '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_m     <= r_slope[r_ch][w_seg];
                    r_b     <= r_icpt[r_ch][w_seg];
                    r_state <= S_MULT;
                end
                S_MULT: begin
                    r_prod  <= w_prod;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    if (w_sum > S_MAX) begin
                        r_result <= RES_MAX;
                        r_of     <= 1'b1;
                        r_uf     <= 1'b0;
                    end else if (w_sum < S_MIN) begin
                        r_result <= RES_MIN;
                        r_of     <= 1'b0;
                        r_uf     <= 1'b1;
                    end else begin
                        r_result <= w_sum[W-1:0];
                        r_of     <= 1'b0;
                        r_uf     <= 1'b0;
                    end
                    r_ack   <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!bus.Begin_FSM_LN) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ACK_LN = r_ack;
    assign bus.O_F    = r_of;
    assign bus.U_F    = r_uf;
    assign bus.RESULT = r_result;
endmodule

// File: tb/tb_linealizador_pwl.sv
// tb/tb_linealizador_pwl.sv - directed vector bench for linealizador_pwl
module tb_linealizador_pwl;
    logic clk;
    logic rst;

    linealizador_pwl_if #(.W(32), .FRAC(16), .SEG_BITS(4), .CH(4)) lif ();

    linealizador_pwl #(.W(32), .FRAC(16), .SEG_BITS(4), .CH(4)) dut (
        .CLK    (clk),
        .RST_LN (rst),
        .bus    (lif.slave)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] t;
        logic [31:0] res;
        logic        of_f;
        logic        uf_f;
    } vec_t;

    vec_t vecs [9];
    int   n_cmp;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [3:0] seg, input logic sel, input logic [31:0] d);
        @(negedge clk);
        lif.COEF_WE   = 1'b1;
        lif.COEF_ADDR = {ch, seg, sel};
        lif.COEF_DATA = d;
        @(posedge clk);
        #1;
        lif.COEF_WE   = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] ch, input logic [31:0] t);
        @(negedge clk);
        lif.Begin_FSM_LN = 1'b1;
        lif.T            = t;
        lif.CH_SEL       = ch;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("ack_edge%0d", e), lif.ACK_LN, (e == 4));
            if (e == 1) begin
                lif.T      = ~t;
                lif.CH_SEL = ch + 2'd1;
            end
        end
    endtask

    task automatic end_op();
        @(negedge clk);
        lif.Begin_FSM_LN = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_drop", lif.ACK_LN, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        lif.Begin_FSM_LN = 1'b0;
        lif.T = '0;
        lif.CH_SEL = '0;
        lif.COEF_WE = 1'b0;
        lif.COEF_ADDR = '0;
        lif.COEF_DATA = '0;

        vecs[0] = '{2'd0, 32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 32'h0000_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{2'd1, 32'h0000_0100, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{2'd2, 32'hFFFF_0000, 32'h0000_0005, 1'b0, 1'b0};
        vecs[4] = '{2'd2, 32'h0001_8000, 32'h0000_0007, 1'b0, 1'b0};
`ifdef LN_ROUND_EN
        vecs[5] = '{2'd3, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b0};
        vecs[8] = '{2'd3, 32'h0000_4000, 32'h0000_0000, 1'b0, 1'b0};
`else
        vecs[5] = '{2'd3, 32'h0000_8000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[8] = '{2'd3, 32'h0000_4000, 32'hFFFF_FFFF, 1'b0, 1'b0};
`endif
        vecs[6] = '{2'd2, 32'h0000_8000, 32'h0000_1234, 1'b0, 1'b0};
        vecs[7] = '{2'd0, 32'h0000_4000, 32'hFFFF_8000, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", lif.ACK_LN, 1'b0);
        chk("rst_of", lif.O_F, 1'b0);
        chk("rst_uf", lif.U_F, 1'b0);
        chk("rst_result", lif.RESULT, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        wr(2'd0, 4'd8, 1'b0, 32'h0001_0000);
        wr(2'd0, 4'd8, 1'b1, 32'h0000_0000);
        wr(2'd0, 4'd4, 1'b0, 32'h0002_0000);
        wr(2'd0, 4'd4, 1'b1, 32'hFFFF_0000);
        wr(2'd1, 4'd15, 1'b0, 32'h7FFF_0000);
        wr(2'd1, 4'd15, 1'b1, 32'h7FFF_0000);
        wr(2'd1, 4'd0, 1'b0, 32'h8000_0000);
        wr(2'd1, 4'd0, 1'b1, 32'h8000_0000);
        wr(2'd2, 4'd0, 1'b0, 32'h0000_0000);
        wr(2'd2, 4'd0, 1'b1, 32'h0000_0005);
        wr(2'd2, 4'd15, 1'b0, 32'h0000_0000);
        wr(2'd2, 4'd15, 1'b1, 32'h0000_0007);
        wr(2'd2, 4'd8, 1'b0, 32'h0000_0000);
        wr(2'd2, 4'd8, 1'b1, 32'h0000_1234);
        wr(2'd3, 4'd8, 1'b0, 32'h0000_0001);
        wr(2'd3, 4'd8, 1'b1, 32'h0000_0000);
        wr(2'd3, 4'd4, 1'b0, 32'hFFFF_FFFF);
        wr(2'd3, 4'd4, 1'b1, 32'h0000_0000);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].ch, vecs[i].t);
            chk($sformatf("v%0d_result", i), lif.RESULT, vecs[i].res);
            chk($sformatf("v%0d_of", i), lif.O_F, vecs[i].of_f);
            chk($sformatf("v%0d_uf", i), lif.U_F, vecs[i].uf_f);
            end_op();
        end

        // Begin held through DONE keeps ACK and must not retrigger.
        run_op(2'd0, 32'h0000_8000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("hold_ack", lif.ACK_LN, 1'b1);
        end
        end_op();
        chk("hold_result_kept", lif.RESULT, 32'h0000_8000);
        @(posedge clk);
        #1;
        chk("idle_ack_low", lif.ACK_LN, 1'b0);

        // Coefficient write attempted in MULT must be dropped.
        @(negedge clk);
        lif.Begin_FSM_LN = 1'b1;
        lif.T = 32'h0000_8000;
        lif.CH_SEL = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        lif.COEF_WE = 1'b1;
        lif.COEF_ADDR = {2'd0, 4'd8, 1'b0};
        lif.COEF_DATA = 32'h0;
        @(posedge clk);
        #1;
        lif.COEF_WE = 1'b0;
        @(posedge clk);
        #1;
        chk("gate_ack", lif.ACK_LN, 1'b1);
        end_op();
        run_op(2'd0, 32'h0000_8000);
        chk("gate_rerun_result", lif.RESULT, 32'h0000_8000);
        end_op();
        run_op(2'd2, 32'h0000_8000);
        chk("gate_ch2_result", lif.RESULT, 32'h0000_1234);
        end_op();

        // Reset while in MULT aborts with no partial result.
        @(negedge clk);
        lif.Begin_FSM_LN = 1'b1;
        lif.T = 32'h0000_8000;
        lif.CH_SEL = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        lif.Begin_FSM_LN = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ack", lif.ACK_LN, 1'b0);
        chk("midrst_result", lif.RESULT, 32'h0);
        chk("midrst_of", lif.O_F, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_idle_ack", lif.ACK_LN, 1'b0);
        run_op(2'd0, 32'h0000_8000);
        chk("midrst_fresh_result", lif.RESULT, 32'h0000_8000);
        end_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
